cmd_seq_wrr_arb: RTL
====================

// Module: cmd_seq_wrr_arb
// PURPOSE
//  Weighted round-robin arbiter sharing one command-sequencer write port among 4 frame-based
//  sensor command sequencers. Each channel may own the port for up to WEIGHT consecutive
//  commands before ownership rotates. A one-entry output register holds the command until the
//  downstream side acknowledges it. Sits between the per-sensor sequencers and the AXI command write port.
// PARAMETERS
//  AXI_WR_ADDR_BITS  14  command write address width
//  WEIGHT_BITS       4   width of per-channel weight (quota) registers
//  DEFAULT_WEIGHT    1   reset value of all four weight registers
// PORTS
//  mclk        in   1     global system clock
//  rst         in   1     reset, synchronous to mclk, active-high
//  cfg_we      in   1     write cfg_weight into the weight register of channel cfg_chn
//  cfg_chn     in   2     channel selected for weight write
//  cfg_weight  in   WEIGHT_BITS  new weight value
//  chn_en      in   4     per-channel enable; a disabled channel is never granted
//  waddrN      in   AXI_WR_ADDR_BITS  channel N command address (N=0..3)
//  wr_enN      in   1     channel N command valid (N=0..3)
//  wdataN      in   32    channel N command data (N=0..3)
//  acknN       out  1     channel N command accepted, 1-cycle pulse (N=0..3)
//  waddr_out   out  AXI_WR_ADDR_BITS  arbitrated command address, valid with wr_en_out
//  wr_en_out   out  1     output register full
//  wdata_out   out  32    arbitrated command data, valid with wr_en_out
//  ackn_out    in   1     downstream accepted the current output command
//  cur_chn     out  2     current or last owner channel
// BEHAVIOUR
//  - Reset values: all acknN=0, wr_en_out=0, waddr_out=0, wdata_out=0, cur_chn=0.
//    Also on reset: state IDLE, round-robin pointer=3 (channel 0 wins first), all weights=DEFAULT_WEIGHT.
//    A weight of 0 is treated as 1.
//  - Request: rq[N] = wr_enN & ~acknN & chn_en[N].
//  - Load slot: a slot exists when (!wr_en_out || ackn_out).
//    On a grant at edge k, all of the following take effect at edge k:
//      waddr_out/wdata_out <= granted channel's inputs; wr_en_out <= 1; acknN pulses for exactly cycle k+1.
//    ackn_out without a grant: wr_en_out <= 0 and data is held. ackn_out with a grant: wr_en_out stays 1.
//  - FSM, state IDLE:
//    on a slot with any rq, pick the first requester after the pointer, going round-robin.
//    Load cnt=weight-1, set pointer=cur_chn=winner, grant it, and go to OWN.
//  - FSM, state OWN (owner = cur_chn):
//    Owner acknN high this cycle: ownership is kept. No channel is granted this cycle if cnt>0.
//      If cnt==0, select round-robin as in IDLE.
//    Owner rq high, cnt>0, slot available: grant the owner and decrement cnt.
//    Owner rq low in a non-ack cycle, or chn_en[owner]=0, or cnt==0:
//      select round-robin as in IDLE, starting after the owner.
//      The owner itself is eligible last and receives a fresh quota if it wins.
//      If no channel requests, go to IDLE.
//  - No slot (wr_en_out=1, ackn_out=0): no grants, no acknN, cnt and state frozen;
//    waddr_out/wdata_out remain stable.
//  - Weight writes take effect at the next quota load. An in-progress quota is not altered.
//  - A command already in the output register is delivered even if its channel becomes disabled.
//  - rst asserted mid-operation: next cycle equals the reset state. A held output command is dropped.
// TESTING
//  1. Weights all 1; all 4 channels hold wr_en=1; ackn_out=1 -> grant order 0,1,2,3,0,1 on consecutive cycles.
//  2. w0=3, w1=1; only channels 0 and 1 request; ackn_out=1 -> ack order 0,0,0,1,0,0,0,1.
//     Each gap after an owner ack is exactly 1 idle cycle.
//  3. After a load, ackn_out=0 for 5 cycles -> wr_en_out=1 with waddr_out/wdata_out constant and no acknN.
//     Raising ackn_out -> the next command loads at the same edge and wr_en_out stays 1.
//  4. chn_en=4'b1101 with all channels requesting -> ack1 is never asserted; order 0,2,3,0.
//  5. Write cfg_weight=0 to channel 2, then only channel 2 requests -> one grant per quota, same as weight 1.
//  6. rst for 1 cycle while channel 3 owns with cnt=2 -> all outputs 0; the next grant goes to channel 0 when it requests.

Source files
------------

// File: rtl/cmd_seq_wrr_arb_if.sv
// cmd_seq_wrr_arb_if: command handshake bundle between four sequencers,
// the arbiter (slave) and the downstream write port.
// Ports: waddrN/wr_enN/wdataN in, acknN back; *_out forward, ackn_out back.
interface cmd_seq_wrr_arb_if #(
  parameter int AXI_WR_ADDR_BITS = 14
);
  logic [AXI_WR_ADDR_BITS-1:0] waddr0;
  logic [AXI_WR_ADDR_BITS-1:0] waddr1;
  logic [AXI_WR_ADDR_BITS-1:0] waddr2;
  logic [AXI_WR_ADDR_BITS-1:0] waddr3;
  logic                        wr_en0;
  logic                        wr_en1;
  logic                        wr_en2;
  logic                        wr_en3;
  logic [31:0]                 wdata0;
  logic [31:0]                 wdata1;
  logic [31:0]                 wdata2;
  logic [31:0]                 wdata3;
  logic                        ackn0;
  logic                        ackn1;
  logic                        ackn2;
  logic                        ackn3;
  logic [AXI_WR_ADDR_BITS-1:0] waddr_out;
  logic                        wr_en_out;
  logic [31:0]                 wdata_out;
  logic                        ackn_out;

  modport slave (
    input  waddr0, waddr1, waddr2, waddr3,
    input  wr_en0, wr_en1, wr_en2, wr_en3,
    input  wdata0, wdata1, wdata2, wdata3,
    output ackn0, ackn1, ackn2, ackn3,
    output waddr_out, wr_en_out, wdata_out,
    input  ackn_out
  );

  modport master (
    output waddr0, waddr1, waddr2, waddr3,
    output wr_en0, wr_en1, wr_en2, wr_en3,
    output wdata0, wdata1, wdata2, wdata3,
    input  ackn0, ackn1, ackn2, ackn3,
    input  waddr_out, wr_en_out, wdata_out,
    output ackn_out
  );
endinterface

// File: rtl/cmd_seq_wrr_arb.sv
// cmd_seq_wrr_arb: weighted round-robin arbiter, 4 sequencers -> 1 write port.
// Ports: mclk, rst (sync, high), cfg_we/cfg_chn/cfg_weight, chn_en, cur_chn, bus.
module cmd_seq_wrr_arb #(
  parameter int AXI_WR_ADDR_BITS = 14,
  parameter int WEIGHT_BITS      = 4,
  parameter int DEFAULT_WEIGHT   = 1
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_chn,
  input  logic [WEIGHT_BITS-1:0] cfg_weight,
  input  logic [3:0]             chn_en,
  output logic [1:0]             cur_chn,
  cmd_seq_wrr_arb_if.slave       bus
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WEIGHT_BITS-1:0] r_cnt;
  logic [WEIGHT_BITS-1:0] w_cnt_nxt;
  logic [WEIGHT_BITS-1:0] r_weight [4];

  logic [1:0]  r_ptr;
  logic [1:0]  r_cur;
  logic [3:0]  r_ackn;
  logic        r_wen;
  logic [AXI_WR_ADDR_BITS-1:0] r_addr;
  logic [31:0] r_data;

  logic [AXI_WR_ADDR_BITS-1:0] w_waddr [4];
  logic [31:0] w_wdata [4];
  logic [3:0]  w_wr_en;
  logic [3:0]  w_rq;
  logic        w_slot;
  logic [2:0]  w_rr;
  logic        w_gnt;
  logic [1:0]  w_gnt_chn;

  // First requester strictly after base; base itself is checked last.
  function automatic logic [2:0] rr_pick(
    input logic [1:0] base,
    input logic [3:0] req
  );
    logic [1:0] c;
    rr_pick = '0;
    for (int i = 4; i >= 1; i--) begin
      c = base + 2'(i);
      if (req[c]) rr_pick = {1'b1, c};
    end
  endfunction

  // Zero weight behaves like one.
  function automatic logic [WEIGHT_BITS-1:0] quota(
    input logic [WEIGHT_BITS-1:0] w
  );
    quota = (w == '0) ? '0 : w - WEIGHT_BITS'(1);
  endfunction

  assign w_waddr[0] = bus.waddr0;
  assign w_waddr[1] = bus.waddr1;
  assign w_waddr[2] = bus.waddr2;
  assign w_waddr[3] = bus.waddr3;
  assign w_wdata[0] = bus.wdata0;
  assign w_wdata[1] = bus.wdata1;
  assign w_wdata[2] = bus.wdata2;
  assign w_wdata[3] = bus.wdata3;
  assign w_wr_en = {bus.wr_en3, bus.wr_en2,
                    bus.wr_en1, bus.wr_en0};

  assign w_rq   = w_wr_en & ~r_ackn & chn_en;
  assign w_slot = !r_wen || bus.ackn_out;
  // In OWN the pointer always equals the owner.
  assign w_rr   = rr_pick(r_ptr, w_rq);

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gnt       = 1'b0;
    w_gnt_chn   = r_cur;
    if (w_slot) begin
      unique case (r_state)
        IDLE: begin
          if (w_rr[2]) begin
            w_gnt       = 1'b1;
            w_gnt_chn   = w_rr[1:0];
            w_cnt_nxt   = quota(r_weight[w_rr[1:0]]);
            w_state_nxt = OWN;
          end
        end
        OWN: begin
          if (r_ackn[r_cur] && r_cnt != '0) begin
            // owner keeps the port through its ack cycle
            w_gnt = 1'b0;
          end else if (w_rq[r_cur] && r_cnt != '0) begin
            w_gnt     = 1'b1;
            w_gnt_chn = r_cur;
            w_cnt_nxt = r_cnt - WEIGHT_BITS'(1);
          end else if (w_rr[2]) begin
            w_gnt     = 1'b1;
            w_gnt_chn = w_rr[1:0];
            w_cnt_nxt = quota(r_weight[w_rr[1:0]]);
          end else begin
            w_state_nxt = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_ptr  <= 2'd3;
      r_cur  <= 2'd0;
      r_ackn <= '0;
      r_wen  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      for (int i = 0; i < 4; i++)
        r_weight[i] <= WEIGHT_BITS'(DEFAULT_WEIGHT);
    end else begin
      if (cfg_we) r_weight[cfg_chn] <= cfg_weight;
      if (w_gnt) begin
        r_ptr  <= w_gnt_chn;
        r_cur  <= w_gnt_chn;
        r_ackn <= 4'b0001 << w_gnt_chn;
        r_wen  <= 1'b1;
        r_addr <= w_waddr[w_gnt_chn];
        r_data <= w_wdata[w_gnt_chn];
      end else begin
        r_ackn <= '0;
        if (bus.ackn_out) r_wen <= 1'b0;
      end
    end
  end

  assign bus.ackn0     = r_ackn[0];
  assign bus.ackn1     = r_ackn[1];
  assign bus.ackn2     = r_ackn[2];
  assign bus.ackn3     = r_ackn[3];
  assign bus.waddr_out = r_addr;
  assign bus.wr_en_out = r_wen;
  assign bus.wdata_out = r_data;
  assign cur_chn       = r_cur;

endmodule
